// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: widths, the FIFO entry bundle
// and the arbiter FSM states.
package wb_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; no fall-through, push refused when full.
// With WB_FWD_EN the storage and read pointer are exported for forwarding.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
`ifdef WB_FWD_EN
    ,
    output wb_entry_t [DEPTH-1:0]    entries,
    output logic [$clog2(DEPTH)-1:0] rd_ptr
`endif
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0]         wr_q;
    logic [AW-1:0]         rd_q;
    logic [AW:0]           cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_q];
    assign count   = cnt_q;

`ifdef WB_FWD_EN
    assign entries = mem;
    assign rd_ptr  = rd_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset: occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU vs buffered load/multiply results into one write port.
// Optional operand forwarding from pending writes when WB_FWD_EN is defined.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [REG_AW-1:0]      lsu_rd,
    input  logic [DATA_W-1:0]      lsu_data,
    output logic                   regWrite,
    output logic [REG_AW-1:0]      wb_rd,
    output logic [DATA_W-1:0]      WriteData,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0]      fwd_rs,
    input  logic [REG_AW-1:0]      fwd_rt,
    output logic                   fwd_rs_hit,
    output logic [DATA_W-1:0]      fwd_rs_data,
    output logic                   fwd_rt_hit,
    output logic [DATA_W-1:0]      fwd_rt_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_state_t     state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [SW-1:0] starve_inc;
    logic          alu_acc;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    wb_entry_t     fifo_head;
    wb_entry_t     sel;
    logic          sel_valid;

`ifdef WB_FWD_EN
    wb_entry_t [DEPTH-1:0] fifo_entries;
    logic [AW-1:0]         fifo_rdptr;
`endif

    assign alu_ready  = (state_q == NORMAL);
    assign lsu_ready  = !fifo_full;
    assign alu_acc    = alu_valid && alu_ready;
    assign fifo_push  = lsu_valid && lsu_ready;
    assign starve_inc = starve_q + SW'(1);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data('{rd: lsu_rd, data: lsu_data}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
`ifdef WB_FWD_EN
        ,
        .entries  (fifo_entries),
        .rd_ptr   (fifo_rdptr)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = '0;
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel       = fifo_head;
        unique case (state_q)
            NORMAL: begin
                if (alu_acc) begin
                    sel_valid = 1'b1;
                    sel       = '{rd: alu_rd, data: alu_data};
                    // Only ALU wins over a waiting FIFO count as starvation.
                    if (!fifo_empty) begin
                        starve_d = starve_inc;
                        if (starve_inc == SW'(STARVE_LIMIT)) state_d = DRAIN;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sel_valid = 1'b1;
                end
            end
            DRAIN: begin
                fifo_pop  = !fifo_empty;
                sel_valid = !fifo_empty;
                state_d   = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // r0 results are consumed but never enable the register-file write.
    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite  <= 1'b0;
            wb_rd     <= '0;
            WriteData <= '0;
        end else begin
            regWrite <= sel_valid && (sel.rd != '0);
            if (sel_valid) begin
                wb_rd     <= sel.rd;
                WriteData <= sel.data;
            end
        end
    end

`ifdef WB_FWD_EN
    function automatic logic [DATA_W:0] fwd_lookup(input logic [REG_AW-1:0] r);
        logic [DATA_W:0] res;
        logic [AW-1:0]   idx;
        res = '0;
        // Walk head to tail so the youngest matching entry is kept.
        for (int i = 0; i < DEPTH; i++) begin
            idx = fifo_rdptr + AW'(i);
            if ((AW+1)'(i) < fifo_count && fifo_entries[idx].rd == r)
                res = {1'b1, fifo_entries[idx].data};
        end
        if (regWrite && wb_rd == r) res = {1'b1, WriteData};
        if (r == '0) res = '0;
        return res;
    endfunction

    assign {fwd_rs_hit, fwd_rs_data} = fwd_lookup(fwd_rs);
    assign {fwd_rt_hit, fwd_rt_data} = fwd_lookup(fwd_rt);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based model.
// Forwarding ports are exercised when WB_FWD_EN is defined.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [3:0]  lsu_rd;
    logic [15:0] lsu_data;
    logic        regWrite;
    logic [3:0]  wb_rd;
    logic [15:0] WriteData;
    logic [2:0]  fifo_count;
`ifdef WB_FWD_EN
    logic [3:0]  fwd_rs;
    logic [3:0]  fwd_rt;
    logic        fwd_rs_hit;
    logic [15:0] fwd_rs_data;
    logic        fwd_rt_hit;
    logic [15:0] fwd_rt_data;
`endif

    wb_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .regWrite   (regWrite),
        .wb_rd      (wb_rd),
        .WriteData  (WriteData),
        .fifo_count (fifo_count)
`ifdef WB_FWD_EN
        ,
        .fwd_rs     (fwd_rs),
        .fwd_rt     (fwd_rt),
        .fwd_rs_hit (fwd_rs_hit),
        .fwd_rs_data(fwd_rs_data),
        .fwd_rt_hit (fwd_rt_hit),
        .fwd_rt_data(fwd_rt_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending slow results as a queue, plus starvation bookkeeping.
    wb_entry_t   q[$];
    bit          drain  = 0;
    int          starve = 0;
    bit          known  = 0;
    bit          e_we   = 0;
    logic [3:0]  e_rd   = 0;
    logic [15:0] e_data = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef WB_FWD_EN
    function automatic logic [16:0] fwd_model(input logic [3:0] r);
        if (r == 0) return '0;
        if (e_we && e_rd == r) return {1'b1, e_data};
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == r) return {1'b1, q[i].data};
        return '0;
    endfunction

    task automatic fwd_check(input logic [3:0] rs, input logic [3:0] rt);
        fwd_rs = rs;
        fwd_rt = rt;
        #1;
        chk("fwd_rs", {15'd0, fwd_rs_hit, fwd_rs_data}, {15'd0, fwd_model(rs)});
        chk("fwd_rt", {15'd0, fwd_rt_hit, fwd_rt_data}, {15'd0, fwd_model(rt)});
    endtask
`endif

    task automatic step(input bit rst, input bit av, input logic [3:0] ard,
                        input logic [15:0] adat, input bit lv,
                        input logic [3:0] lrd, input logic [15:0] ldat);
        bit        acc;
        bit        psh;
        wb_entry_t h;
        @(negedge clk);
        reset     = rst;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ldat;
        #1;
        if (known && !rst) begin
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, !drain});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, q.size() < DEPTH});
        end
        acc = av && !drain;
        psh = lv && (q.size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            q.delete();
            drain  = 0;
            starve = 0;
            e_we   = 0;
            e_rd   = 0;
            e_data = 0;
            known  = 1;
        end else begin
            if (acc) begin
                e_we   = (ard != 0);
                e_rd   = ard;
                e_data = adat;
                if (q.size() == 0) starve = 0;
                else begin
                    starve++;
                    if (starve >= STARVE_LIMIT) drain = 1;
                end
            end else if (q.size() != 0) begin
                h      = q.pop_front();
                e_we   = (h.rd != 0);
                e_rd   = h.rd;
                e_data = h.data;
                starve = 0;
                drain  = 0;
            end else begin
                e_we   = 0;
                starve = 0;
            end
            if (psh) q.push_back('{rd: lrd, data: ldat});
        end
        #1;
        if (known) begin
            chk("regWrite", {31'd0, regWrite}, {31'd0, e_we});
            chk("wb_rd", {28'd0, wb_rd}, {28'd0, e_rd});
            chk("WriteData", {16'd0, WriteData}, {16'd0, e_data});
            chk("fifo_count", {29'd0, fifo_count}, q.size());
`ifdef WB_FWD_EN
            fwd_check(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
`endif
        end
    endtask

    initial begin
        reset = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
`ifdef WB_FWD_EN
        fwd_rs = 0; fwd_rt = 0;
`endif
        // Reset held with ALU traffic present, then first write one cycle later
        step(1, 1, 5, 16'h0055, 0, 0, 0);
        step(1, 1, 5, 16'h0055, 0, 0, 0);
        step(0, 1, 5, 16'h0055, 0, 0, 0);
        // ALU only, back to back
        step(0, 1, 1, 16'h0001, 0, 0, 0);
        step(0, 1, 3, 16'h0003, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Fill FIFO under ALU pressure, forced drain, held 5th push
        step(0, 1, 1, 16'h000a, 1, 2, 16'h0002);
        step(0, 1, 1, 16'h000b, 1, 4, 16'h0004);
        step(0, 1, 1, 16'h000c, 1, 6, 16'h0006);
        step(0, 1, 1, 16'h000d, 1, 8, 16'h0008);
        step(0, 1, 1, 16'h000e, 1, 10, 16'h000a);
        step(0, 1, 1, 16'h000f, 1, 10, 16'h000a);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
        // Push and pop in the same cycle with ALU idle
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 2, 16'h0022);
        step(0, 0, 0, 0, 1, 4, 16'h0044);
        step(0, 0, 0, 0, 0, 0, 0);
        // r0 discard
        step(0, 1, 0, 16'hffff, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        // Two pending writes to r7; youngest must forward
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 16'h0101, 1, 7, 16'h1111);
        step(0, 1, 1, 16'h0102, 1, 7, 16'h2222);
`ifdef WB_FWD_EN
        fwd_check(7, 7);
        chk("fwd_r7_hit", {31'd0, fwd_rs_hit}, 32'd1);
        chk("fwd_r7_data", {16'd0, fwd_rs_data}, 32'h2222);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        // Random traffic with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)),
                 16'($urandom),
                 $urandom_range(0, 2) != 0,
                 4'($urandom_range(0, 15)),
                 16'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
